// File: rtl/sha512_w_mem.sv
// rtl/sha512_w_mem.sv - SHA-512 message schedule: 16-word sliding window producing W[0..79].
// Optional SHA512_W_MEM_ERR_EN adds a sticky err flag for next issued at the final round.
module sha512_w_mem (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic          next,
    input  logic [1023:0] block,
    output logic [63:0]   w,
    output logic [6:0]    round,
    output logic          last
`ifdef SHA512_W_MEM_ERR_EN
    ,
    output logic          err
`endif
);

    localparam logic [6:0] LAST_ROUND = 7'd79;

    logic [63:0] w_mem_q [16];
    logic [63:0] w_mem_d [16];
    logic [6:0]  ctr_q;
    logic [6:0]  ctr_d;
    logic [63:0] w_new;
    logic [63:0] s0;
    logic [63:0] s1;

    always_comb begin
        s0 = {w_mem_q[1][0], w_mem_q[1][63:1]}
           ^ {w_mem_q[1][7:0], w_mem_q[1][63:8]}
           ^ (w_mem_q[1] >> 7);
        s1 = {w_mem_q[14][18:0], w_mem_q[14][63:19]}
           ^ {w_mem_q[14][60:0], w_mem_q[14][63:61]}
           ^ (w_mem_q[14] >> 6);
        w_new = s1 + w_mem_q[9] + s0 + w_mem_q[0];
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_mem_d[i] = w_mem_q[i];
        end
        ctr_d = ctr_q;
        if (init) begin
            for (int i = 0; i < 16; i++) begin
                w_mem_d[i] = block[1023 - 64*i -: 64];
            end
            ctr_d = 7'd0;
        end else if (next && (ctr_q != LAST_ROUND)) begin
            ctr_d = ctr_q + 7'd1;
            // The first 16 rounds read the loaded block directly; sliding starts at round 16.
            if (ctr_q >= 7'd16) begin
                for (int i = 0; i < 15; i++) begin
                    w_mem_d[i] = w_mem_q[i + 1];
                end
                w_mem_d[15] = w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                w_mem_q[i] <= 64'd0;
            end
            ctr_q <= 7'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                w_mem_q[i] <= w_mem_d[i];
            end
            ctr_q <= ctr_d;
        end
    end

`ifdef SHA512_W_MEM_ERR_EN
    logic err_q;
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (init) begin
            err_d = 1'b0;
        end else if (next && (ctr_q == LAST_ROUND)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign w     = (ctr_q < 7'd16) ? w_mem_q[ctr_q[3:0]] : w_new;
    assign round = ctr_q;
    assign last  = (ctr_q == LAST_ROUND);

endmodule
